// File: rtl/issue_sched.sv
// Dispatch scheduler and CDB arbiter: picks one ready add and one ready mul/div
// entry per cycle, tracks the mul/div unit, arbitrates the CDB (optional macro SCHED_RR_EN).
module issue_sched #(
   parameter int NRS     = 3,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 6
) (
   input  logic           clk2,
   input  logic           rst,
   input  logic           flush,
   input  logic [NRS-1:0] add_rdy,
   input  logic [NRS-1:0] mul_rdy,
   input  logic [NRS-1:0] mul_isdiv,
   output logic           add_go,
   output logic [2:0]     add_idx,
   output logic           mul_go,
   output logic [2:0]     mul_idx,
   output logic           mul_busy,
   output logic           cdb_add,
   output logic           cdb_mul,
   output logic           stall_add
);

   localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
   localparam logic [NRS-1:0] ONE = {{(NRS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_t;

   mul_state_t    state, state_n;
   logic [CW-1:0] cnt, cnt_n;

   // Returns {found, idx}: first set bit of rdy searching upward from start, wrapping.
   function automatic logic [3:0] pick(input logic [NRS-1:0] rdy, input logic [2:0] start);
      logic [3:0] r;
      int j;
      r = '0;
      for (int k = NRS - 1; k >= 0; k--) begin
         j = (int'(start) + k) % NRS;
         if (rdy[j]) r = {1'b1, 3'(j)};
      end
      return r;
   endfunction

   // The RS clears a dispatched entry one cycle late, so the index on the go
   // outputs this cycle must not be picked again for the next cycle.
   logic [NRS-1:0] add_mask, mul_mask;
   assign add_mask = add_go ? (ONE << add_idx) : '0;
   assign mul_mask = mul_go ? (ONE << mul_idx) : '0;

   logic [2:0] add_start, mul_start;
`ifdef SCHED_RR_EN
   logic [2:0] add_ptr, mul_ptr;
   assign add_start = add_ptr;
   assign mul_start = mul_ptr;
`else
   assign add_start = 3'd0;
   assign mul_start = 3'd0;
`endif

   logic [3:0] add_sel, mul_sel;
   logic       sel_isdiv;
   assign add_sel   = pick(add_rdy & ~add_mask, add_start);
   assign mul_sel   = pick(mul_rdy & ~mul_mask, mul_start);
   assign sel_isdiv = |(mul_isdiv & (ONE << mul_sel[2:0]));

   logic       add_go_n, mul_go_n, mul_busy_n, cdb_add_n, cdb_mul_n, stall_n, mul_done_n;
   logic [2:0] add_idx_n, mul_idx_n;

   // State register (all registered state and outputs).
   always_ff @(posedge clk2) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         add_go    <= 1'b0;
         add_idx   <= '0;
         mul_go    <= 1'b0;
         mul_idx   <= '0;
         mul_busy  <= 1'b0;
         cdb_add   <= 1'b0;
         cdb_mul   <= 1'b0;
         stall_add <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         add_go    <= add_go_n;
         add_idx   <= add_idx_n;
         mul_go    <= mul_go_n;
         mul_idx   <= mul_idx_n;
         mul_busy  <= mul_busy_n;
         cdb_add   <= cdb_add_n;
         cdb_mul   <= cdb_mul_n;
         stall_add <= stall_n;
      end
   end

`ifdef SCHED_RR_EN
   always_ff @(posedge clk2) begin
      if (rst || flush) begin
         add_ptr <= '0;
         mul_ptr <= '0;
      end else begin
         if (add_go_n) add_ptr <= (add_sel[2:0] == 3'(NRS - 1)) ? 3'd0 : add_sel[2:0] + 3'd1;
         if (mul_go_n) mul_ptr <= (mul_sel[2:0] == 3'(NRS - 1)) ? 3'd0 : mul_sel[2:0] + 3'd1;
      end
   end
`endif

   // Next-state logic for the mul/div unit.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         S_IDLE, S_DONE: begin
            if (mul_sel[3]) begin
               state_n = S_RUN;
               cnt_n   = sel_isdiv ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
            end else begin
               state_n = S_IDLE;
            end
         end
         S_RUN: begin
            if (cnt == '0) state_n = S_DONE;
            else           cnt_n   = cnt - 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
      if (flush) begin
         state_n = S_IDLE;
         cnt_n   = '0;
      end
   end

   // Output logic: values the output registers take at the next edge.
   always_comb begin
      mul_done_n = (state == S_RUN) && (cnt == '0);
      // An add result due in a mul DONE cycle is held one cycle; no new add behind it.
      stall_n    = add_go && mul_done_n;
      cdb_mul_n  = mul_done_n;
      cdb_add_n  = (add_go && !mul_done_n) || stall_add;
      add_go_n   = add_sel[3] && !stall_n;
      add_idx_n  = add_go_n ? add_sel[2:0] : 3'd0;
      mul_go_n   = ((state == S_IDLE) || (state == S_DONE)) && mul_sel[3];
      mul_idx_n  = mul_go_n ? mul_sel[2:0] : 3'd0;
      mul_busy_n = (state_n == S_RUN) && !mul_go_n;
      if (flush) begin
         stall_n    = 1'b0;
         cdb_mul_n  = 1'b0;
         cdb_add_n  = 1'b0;
         add_go_n   = 1'b0;
         add_idx_n  = 3'd0;
         mul_go_n   = 1'b0;
         mul_idx_n  = 3'd0;
         mul_busy_n = 1'b0;
      end
   end

endmodule

// File: tb/tb_issue_sched.sv
// Directed self-checking bench for issue_sched: reset, add stream, mul/div latency,
// CDB conflict, flush, reset mid-operation and dispatch order.
module tb_issue_sched;

   logic       clk2 = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [2:0] add_rdy = '0;
   logic [2:0] mul_rdy = '0;
   logic [2:0] mul_isdiv = '0;
   logic       add_go, mul_go, mul_busy, cdb_add, cdb_mul, stall_add;
   logic [2:0] add_idx, mul_idx;

   int n_checks = 0;
   int n_fail = 0;

   issue_sched #(.NRS(3), .MUL_LAT(3), .DIV_LAT(6)) dut (
      .clk2(clk2), .rst(rst), .flush(flush),
      .add_rdy(add_rdy), .mul_rdy(mul_rdy), .mul_isdiv(mul_isdiv),
      .add_go(add_go), .add_idx(add_idx), .mul_go(mul_go), .mul_idx(mul_idx),
      .mul_busy(mul_busy), .cdb_add(cdb_add), .cdb_mul(cdb_mul), .stall_add(stall_add)
   );

   // Clock / reset
   always #5 clk2 = ~clk2;

   task automatic step();
      @(posedge clk2);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; flush = 1'b0;
      add_rdy = '0; mul_rdy = '0; mul_isdiv = '0;
      step(); step();
      rst = 1'b0;
   endtask

   // Outputs packed {add_go,add_idx,mul_go,mul_idx,mul_busy,cdb_add,cdb_mul,stall_add}
   function automatic logic [11:0] outs();
      return {add_go, add_idx, mul_go, mul_idx, mul_busy, cdb_add, cdb_mul, stall_add};
   endfunction

   task automatic test_reset();
      rst = 1'b1; add_rdy = 3'b111; mul_rdy = 3'b111; mul_isdiv = '0;
      step();
      n_checks++;
      if (outs() !== 12'h000) begin n_fail++; $display("FAIL reset_c1: got %h expected 000", outs()); end
      step();
      n_checks++;
      if (outs() !== 12'h000) begin n_fail++; $display("FAIL reset_c2: got %h expected 000", outs()); end
      rst = 1'b0;
      step();
      n_checks++;
      if ({add_go, add_idx} !== 4'b1000) begin n_fail++; $display("FAIL reset_first_add: got %b expected 1000", {add_go, add_idx}); end
      n_checks++;
      if ({mul_go, mul_idx} !== 4'b1000) begin n_fail++; $display("FAIL reset_first_mul: got %b expected 1000", {mul_go, mul_idx}); end
   endtask

   task automatic test_add_stream();
      logic [2:0] exp_idx [3];
      exp_idx[0] = 3'd0; exp_idx[1] = 3'd2; exp_idx[2] = 3'd0;
      apply_reset();
      add_rdy = 3'b101;
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++;
         if ({add_go, add_idx} !== {1'b1, exp_idx[c]}) begin
            n_fail++; $display("FAIL add_stream_go c%0d: got %b/%0d expected 1/%0d", c, add_go, add_idx, exp_idx[c]);
         end
         n_checks++;
         if (cdb_add !== (c > 0)) begin n_fail++; $display("FAIL add_stream_cdb c%0d: got %b expected %b", c, cdb_add, c > 0); end
      end
      add_rdy = '0;
      step();
      n_checks++;
      if ({add_go, cdb_add} !== 2'b01) begin n_fail++; $display("FAIL add_stream_tail: got %b expected 01", {add_go, cdb_add}); end
   endtask

   task automatic run_mul_lat(input logic isdiv, input int lat);
      apply_reset();
      mul_rdy = 3'b010; mul_isdiv = isdiv ? 3'b010 : 3'b000;
      step();
      n_checks++;
      if ({mul_go, mul_idx, mul_busy, cdb_mul} !== 6'b100100) begin
         n_fail++; $display("FAIL lat%0d_go: got %b expected 100100", lat, {mul_go, mul_idx, mul_busy, cdb_mul});
      end
      mul_rdy = '0;
      for (int k = 1; k < lat; k++) begin
         step();
         n_checks++;
         if ({mul_go, mul_busy, cdb_mul} !== 3'b010) begin
            n_fail++; $display("FAIL lat%0d_run k%0d: got %b expected 010", lat, k, {mul_go, mul_busy, cdb_mul});
         end
      end
      step();
      n_checks++;
      if ({mul_go, mul_busy, cdb_mul} !== 3'b001) begin
         n_fail++; $display("FAIL lat%0d_done: got %b expected 001", lat, {mul_go, mul_busy, cdb_mul});
      end
      step();
      n_checks++;
      if ({mul_busy, cdb_mul} !== 2'b00) begin n_fail++; $display("FAIL lat%0d_after: got %b expected 00", lat, {mul_busy, cdb_mul}); end
   endtask

   task automatic test_mul_div_latency();
      run_mul_lat(1'b0, 3);
      run_mul_lat(1'b1, 6);
   endtask

   task automatic test_cdb_conflict();
      logic [2:0] exp_idx;
`ifdef SCHED_RR_EN
      exp_idx = 3'd1;
`else
      exp_idx = 3'd0;
`endif
      apply_reset();
      mul_rdy = 3'b010;
      step();                        // T0: mul_go, DONE at T0+3
      mul_rdy = '0;
      step();                        // T0+1
      add_rdy = 3'b011;
      step();                        // T0+2: add_go idx0
      n_checks++;
      if ({add_go, add_idx} !== 4'b1000) begin n_fail++; $display("FAIL conflict_add_go: got %b expected 1000", {add_go, add_idx}); end
      step();                        // T0+3: mul wins, add held
      n_checks++;
      if ({cdb_mul, cdb_add, stall_add, add_go} !== 4'b1010) begin
         n_fail++; $display("FAIL conflict_done: got %b expected 1010", {cdb_mul, cdb_add, stall_add, add_go});
      end
      step();                        // T0+4: held add result drains
      n_checks++;
      if ({cdb_mul, cdb_add, stall_add} !== 3'b010) begin
         n_fail++; $display("FAIL conflict_drain: got %b expected 010", {cdb_mul, cdb_add, stall_add});
      end
      n_checks++;
      if ({add_go, add_idx} !== {1'b1, exp_idx}) begin
         n_fail++; $display("FAIL conflict_resume: got %b expected %b", {add_go, add_idx}, {1'b1, exp_idx});
      end
      add_rdy = '0;
   endtask

   task automatic test_flush();
      apply_reset();
      mul_rdy = 3'b010; mul_isdiv = 3'b010;
      step();                        // T: div go, counter 5
      mul_rdy = '0;
      step(); step();                // T+2: counter 3
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_checks++;
      if ({mul_busy, cdb_mul, mul_go, add_go, cdb_add} !== 5'b00000) begin
         n_fail++; $display("FAIL flush_kill: got %b expected 00000", {mul_busy, cdb_mul, mul_go, add_go, cdb_add});
      end
      mul_rdy = 3'b001; mul_isdiv = '0;
      step();                        // F+1: new mul accepted
      n_checks++;
      if ({mul_go, mul_idx} !== 4'b1000) begin n_fail++; $display("FAIL flush_newgo: got %b expected 1000", {mul_go, mul_idx}); end
      mul_rdy = '0;
      for (int k = 1; k <= 3; k++) begin
         step();
         n_checks++;
         if (cdb_mul !== (k == 3)) begin n_fail++; $display("FAIL flush_cdb k%0d: got %b expected %b", k, cdb_mul, k == 3); end
      end
      // Flush also kills a pending add result.
      apply_reset();
      add_rdy = 3'b001;
      step();
      flush = 1'b1; add_rdy = '0;
      step();
      flush = 1'b0;
      n_checks++;
      if ({add_go, cdb_add, stall_add} !== 3'b000) begin
         n_fail++; $display("FAIL flush_add: got %b expected 000", {add_go, cdb_add, stall_add});
      end
   endtask

   task automatic test_rst_mid();
      apply_reset();
      mul_rdy = 3'b010;
      step();
      mul_rdy = '0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         n_checks++;
         if ({cdb_mul, mul_busy} !== 2'b00) begin n_fail++; $display("FAIL rst_mid k%0d: got %b expected 00", k, {cdb_mul, mul_busy}); end
      end
   endtask

   task automatic test_rdy_drop();
      apply_reset();
      @(negedge clk2);
      add_rdy = 3'b100;
      #2 add_rdy = '0;
      step();
      n_checks++;
      if (add_go !== 1'b0) begin n_fail++; $display("FAIL rdy_drop: got %b expected 0", add_go); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_idx [4];
`ifdef SCHED_RR_EN
      exp_idx[0] = 3'd0; exp_idx[1] = 3'd1; exp_idx[2] = 3'd2; exp_idx[3] = 3'd0;
`else
      exp_idx[0] = 3'd0; exp_idx[1] = 3'd1; exp_idx[2] = 3'd0; exp_idx[3] = 3'd1;
`endif
      apply_reset();
      add_rdy = 3'b111;
      for (int c = 0; c < 4; c++) begin
         step();
         n_checks++;
         if ({add_go, add_idx} !== {1'b1, exp_idx[c]}) begin
            n_fail++; $display("FAIL order c%0d: got %b/%0d expected 1/%0d", c, add_go, add_idx, exp_idx[c]);
         end
      end
      add_rdy = '0;
   endtask

   initial begin
      test_reset();
      test_add_stream();
      test_mul_div_latency();
      test_cdb_conflict();
      test_flush();
      test_rst_mid();
      test_rdy_drop();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
